// File: rtl/if_stage_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_stage_fetch_queue_if
//   Bundles the signals between pre-IF, the instruction SRAM response side,
//   the flush sources, ID and the IF fetch queue.
//
//   Parameter
//     MAX_OUTSTANDING : sets the width of cancel_cnt (clog2(MAX_OUTSTANDING+1))
//
//   Signal groups
//     issue_*           : fetch issued by pre-IF this cycle; issue_allow goes back
//     inst_sram_*       : in-order SRAM responses
//     wb_ex / ertn_flush / br_taken_cancel : flush sources
//     ID_allowin, IF_to_ID_valid, IF_to_ID_BUS : buffer head toward ID
//     cancel_cnt        : stale responses still to be discarded
//
//   Handshake semantics:
//     issue_valid is only meaningful while issue_allow is high; an issue is
//     taken when issue_valid is high and no flush is active.  Toward ID an
//     entry transfers on a cycle where IF_to_ID_valid && ID_allowin and no
//     flush is active; IF_to_ID_BUS holds steady until that transfer.
//
//   Modports
//     master : the surrounding pipeline (drives issue/response/flush/allowin)
//     slave  : the fetch queue itself
// -----------------------------------------------------------------------------
interface if_stage_fetch_queue_if #(
   parameter int MAX_OUTSTANDING = 2
);

   localparam int CANCEL_W = $clog2(MAX_OUTSTANDING + 1);

   logic                issue_valid;
   logic [31:0]         issue_pc;
   logic                issue_ex;
   logic [14:0]         issue_ex_code;
   logic [31:0]         issue_ex_vaddr;
   logic                issue_allow;
   logic                inst_sram_data_ok;
   logic [31:0]         inst_sram_rdata;
   logic                wb_ex;
   logic                ertn_flush;
   logic                br_taken_cancel;
   logic                ID_allowin;
   logic                IF_to_ID_valid;
   logic [111:0]        IF_to_ID_BUS;
   logic [CANCEL_W-1:0] cancel_cnt;

   modport master (
      output issue_valid, issue_pc, issue_ex, issue_ex_code, issue_ex_vaddr,
      output inst_sram_data_ok, inst_sram_rdata,
      output wb_ex, ertn_flush, br_taken_cancel, ID_allowin,
      input  issue_allow, IF_to_ID_valid, IF_to_ID_BUS, cancel_cnt
   );

   modport slave (
      input  issue_valid, issue_pc, issue_ex, issue_ex_code, issue_ex_vaddr,
      input  inst_sram_data_ok, inst_sram_rdata,
      input  wb_ex, ertn_flush, br_taken_cancel, ID_allowin,
      output issue_allow, IF_to_ID_valid, IF_to_ID_BUS, cancel_cnt
   );

endinterface

// File: rtl/if_stage_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_stage_fetch_queue
//   IF stage with up to MAX_OUTSTANDING in-order instruction SRAM requests in
//   flight and a DEPTH-entry instruction buffer toward ID.  After a flush the
//   responses belonging to requests issued before it are counted in
//   cancel_cnt and dropped as they arrive, while new fetches keep flowing.
//
//   Parameters
//     DEPTH           : instruction buffer entries (power of two, >= 2)
//     MAX_OUTSTANDING : SRAM requests in flight, stale ones included (>= 1)
//
//   Ports
//     clk    : clock
//     resetn : asynchronous active-low reset
//     fq     : if_stage_fetch_queue_if.slave (issue, response, flush, ID side)
//
//   IF_to_ID_BUS layout: {pc[31:0], inst[31:0], ex, ex_code[14:0], ex_vaddr[31:0]}
// -----------------------------------------------------------------------------
module if_stage_fetch_queue #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   if_stage_fetch_queue_if.slave fq
);

   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int BCNT_W = $clog2(DEPTH + 1);
   localparam int BPTR_W = $clog2(DEPTH);
   localparam int PPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        ex;
      logic [14:0] ex_code;
      logic [31:0] ex_vaddr;
   } pend_t;

   // pending-request queue
   pend_t                      pend_q [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] pend_vld_q, pend_vld_d;
   logic [PPTR_W-1:0]          pend_rd_q, pend_rd_d;
   logic [PPTR_W-1:0]          pend_wr_q, pend_wr_d;
   logic [CNT_W-1:0]           pend_cnt_q, pend_cnt_d;

   // output buffer toward ID
   logic [111:0]               buf_q [DEPTH];
   logic [BPTR_W-1:0]          buf_rd_q, buf_rd_d;
   logic [BPTR_W-1:0]          buf_wr_q, buf_wr_d;
   logic [BCNT_W-1:0]          buf_cnt_q, buf_cnt_d;

   logic [CNT_W-1:0]           cancel_cnt_q, cancel_cnt_d;
   logic                       ex_hold_q, ex_hold_d;

   logic                       flush;
   pend_t                      head;
   pend_t                      pend_din;
   logic                       head_vld;
   logic                       resp_drop;
   logic                       resp_data;
   logic                       resp_ex;
   logic                       resp_bad;
   logic                       pend_push;
   logic                       pend_pop;
   logic                       buf_push;
   logic                       buf_pop;
   logic [111:0]               buf_din;
   logic [CNT_W-1:0]           nonex_cnt;
   logic [31:0]                cancel_sum;
   logic [31:0]                sum_out;
   logic [31:0]                sum_buf;

   // Pending queue depth need not be a power of two, so wrap explicitly.
   function automatic logic [PPTR_W-1:0] pend_inc(input logic [PPTR_W-1:0] p);
      return (p == PPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign flush    = fq.wb_ex | fq.ertn_flush | fq.br_taken_cancel;
   assign head     = pend_q[pend_rd_q];
   assign head_vld = (pend_cnt_q != '0);

   // Response matching: stale responses first, then the pending head.  An
   // exception entry at the head never waits for SRAM data.
   assign resp_drop = fq.inst_sram_data_ok && (cancel_cnt_q != '0);
   assign resp_data = fq.inst_sram_data_ok && !resp_drop && head_vld && !head.ex;
   assign resp_ex   = !resp_drop && head_vld && head.ex;
   assign resp_bad  = fq.inst_sram_data_ok && !resp_drop && !resp_data;

   assign pend_push = fq.issue_valid && !flush;
   assign pend_pop  = (resp_data || resp_ex) && !flush;
   assign buf_push  = pend_pop;
   assign buf_pop   = fq.IF_to_ID_valid && fq.ID_allowin && !flush;

   assign pend_din  = '{pc:       fq.issue_pc,
                        ex:       fq.issue_ex,
                        ex_code:  fq.issue_ex_code,
                        ex_vaddr: fq.issue_ex_vaddr};
   assign buf_din   = {head.pc, (resp_ex ? 32'h0 : fq.inst_sram_rdata),
                       head.ex, head.ex_code, head.ex_vaddr};

   // Non-exception pending entries each still owe an SRAM response.
   always_comb begin
      nonex_cnt = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (pend_vld_q[i] && !pend_q[i].ex) begin
            nonex_cnt = nonex_cnt + 1'b1;
         end
      end
   end

   // Buffer space is reserved for every pending entry, so a response can
   // always be pushed without checking for room.
   always_comb begin
      sum_out = 32'(pend_cnt_q) + 32'(cancel_cnt_q);
      sum_buf = 32'(pend_cnt_q) + 32'(buf_cnt_q);
   end

   assign fq.issue_allow    = resetn && !ex_hold_q &&
                              (sum_out < $unsigned(MAX_OUTSTANDING)) &&
                              (sum_buf < $unsigned(DEPTH));
   assign fq.IF_to_ID_valid = (buf_cnt_q != '0);
   assign fq.IF_to_ID_BUS   = fq.IF_to_ID_valid ? buf_q[buf_rd_q] : '0;
   assign fq.cancel_cnt     = cancel_cnt_q;

   always_comb begin
      pend_vld_d   = pend_vld_q;
      pend_rd_d    = pend_rd_q;
      pend_wr_d    = pend_wr_q;
      pend_cnt_d   = pend_cnt_q;
      buf_rd_d     = buf_rd_q;
      buf_wr_d     = buf_wr_q;
      buf_cnt_d    = buf_cnt_q;
      cancel_cnt_d = cancel_cnt_q;
      ex_hold_d    = ex_hold_q;
      cancel_sum   = 32'(cancel_cnt_q) + 32'(nonex_cnt) +
                     {31'd0, fq.issue_valid & ~fq.issue_ex};

      if (flush) begin
         // Every request that will still answer becomes stale, including a
         // request issued this very cycle; a response arriving now retires one.
         if (fq.inst_sram_data_ok && (cancel_sum != 32'd0)) begin
            cancel_sum = cancel_sum - 32'd1;
         end
         cancel_cnt_d = CNT_W'(cancel_sum);
         pend_vld_d   = '0;
         pend_rd_d    = '0;
         pend_wr_d    = '0;
         pend_cnt_d   = '0;
         buf_rd_d     = '0;
         buf_wr_d     = '0;
         buf_cnt_d    = '0;
         ex_hold_d    = 1'b0;
      end else begin
         if (resp_drop) begin
            cancel_cnt_d = cancel_cnt_q - 1'b1;
         end
         if (pend_pop) begin
            pend_vld_d[pend_rd_q] = 1'b0;
            pend_rd_d             = pend_inc(pend_rd_q);
         end
         if (pend_push) begin
            pend_vld_d[pend_wr_q] = 1'b1;
            pend_wr_d             = pend_inc(pend_wr_q);
            if (fq.issue_ex) begin
               ex_hold_d = 1'b1;
            end
         end
         pend_cnt_d = pend_cnt_q + CNT_W'(pend_push) - CNT_W'(pend_pop);
         if (buf_push) begin
            buf_wr_d = buf_wr_q + 1'b1;
         end
         if (buf_pop) begin
            buf_rd_d = buf_rd_q + 1'b1;
         end
         buf_cnt_d = buf_cnt_q + BCNT_W'(buf_push) - BCNT_W'(buf_pop);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_vld_q   <= '0;
         pend_rd_q    <= '0;
         pend_wr_q    <= '0;
         pend_cnt_q   <= '0;
         buf_rd_q     <= '0;
         buf_wr_q     <= '0;
         buf_cnt_q    <= '0;
         cancel_cnt_q <= '0;
         ex_hold_q    <= 1'b0;
      end else begin
         pend_vld_q   <= pend_vld_d;
         pend_rd_q    <= pend_rd_d;
         pend_wr_q    <= pend_wr_d;
         pend_cnt_q   <= pend_cnt_d;
         buf_rd_q     <= buf_rd_d;
         buf_wr_q     <= buf_wr_d;
         buf_cnt_q    <= buf_cnt_d;
         cancel_cnt_q <= cancel_cnt_d;
         ex_hold_q    <= ex_hold_d;
      end
   end

   // Payload storage: occupancy is tracked by the control registers above,
   // so the data itself needs no reset.
   always_ff @(posedge clk) begin
      if (pend_push) begin
         pend_q[pend_wr_q] <= pend_din;
      end
      if (buf_push) begin
         buf_q[buf_wr_q] <= buf_din;
      end
   end

   // A response with nothing stale to drop and no non-exception head to
   // match is a protocol violation; it is ignored by the logic above.
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn) !resp_bad);

endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_stage_fetch_queue
//   Bench for if_stage_fetch_queue (DEPTH=4, MAX_OUTSTANDING=2).  Directed
//   scenario tasks plus a randomized run compared against a queue-level model.
// -----------------------------------------------------------------------------
module tb_if_stage_fetch_queue;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic        ex;
      logic [14:0] code;
      logic [31:0] vaddr;
   } req_t;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   if_stage_fetch_queue_if #(.MAX_OUTSTANDING(MAX_OUT)) fq();

   if_stage_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .fq     (fq)
   );

   // ---------------- reference model + scoreboard ----------------
   req_t         m_pend[$];
   logic [111:0] exp_q[$];
   int           m_cancel;
   bit           m_hold;
   int           checks;
   int           errors;

   function automatic bit m_allow();
      return !m_hold && (m_pend.size() + m_cancel < MAX_OUT) &&
             (m_pend.size() + exp_q.size() < DEPTH);
   endfunction

   function automatic logic [111:0] m_bus();
      return (exp_q.size() != 0) ? exp_q[0] : 112'h0;
   endfunction

   function automatic bit m_rsp_legal();
      return (m_cancel > 0) || ((m_pend.size() != 0) && !m_pend[0].ex);
   endfunction

   task automatic model_clear();
      m_pend.delete();
      exp_q.delete();
      m_cancel = 0;
      m_hold   = 1'b0;
   endtask

   task automatic model_step();
      bit   flush;
      bit   dok;
      int   n;
      req_t r;
      flush = fq.wb_ex | fq.ertn_flush | fq.br_taken_cancel;
      dok   = fq.inst_sram_data_ok;
      if (flush) begin
         n = m_cancel;
         foreach (m_pend[i]) if (!m_pend[i].ex) n++;
         if (fq.issue_valid && !fq.issue_ex) n++;
         if (dok && n > 0) n--;
         m_cancel = n;
         m_pend.delete();
         exp_q.delete();
         m_hold = 1'b0;
      end else begin
         if (exp_q.size() != 0 && fq.ID_allowin) void'(exp_q.pop_front());
         if (dok && m_cancel > 0) begin
            m_cancel--;
         end else if (dok && m_pend.size() != 0 && !m_pend[0].ex) begin
            r = m_pend.pop_front();
            exp_q.push_back({r.pc, fq.inst_sram_rdata, r.ex, r.code, r.vaddr});
         end else if (m_pend.size() != 0 && m_pend[0].ex) begin
            r = m_pend.pop_front();
            exp_q.push_back({r.pc, 32'h0, r.ex, r.code, r.vaddr});
         end
         if (fq.issue_valid) begin
            m_pend.push_back('{pc: fq.issue_pc, ex: fq.issue_ex,
                               code: fq.issue_ex_code, vaddr: fq.issue_ex_vaddr});
            if (fq.issue_ex) m_hold = 1'b1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      fq.issue_valid       = 1'b0;
      fq.issue_pc          = 32'h0;
      fq.issue_ex          = 1'b0;
      fq.issue_ex_code     = 15'h0;
      fq.issue_ex_vaddr    = 32'h0;
      fq.inst_sram_data_ok = 1'b0;
      fq.inst_sram_rdata   = 32'h0;
      fq.wb_ex             = 1'b0;
      fq.ertn_flush        = 1'b0;
      fq.br_taken_cancel   = 1'b0;
      fq.ID_allowin        = 1'b0;
   endtask

   // one clock: the model consumes the inputs seen at the edge, outputs are
   // sampled 1ns later
   task automatic tick();
      @(posedge clk);
      if (resetn) model_step();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      model_clear();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fq.IF_to_ID_valid); end
      checks++; if (fq.IF_to_ID_BUS !== 112'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", fq.IF_to_ID_BUS); end
      checks++; if (fq.issue_allow !== 1'b0) begin errors++; $display("FAIL reset_allow: got %b want 0", fq.issue_allow); end
      checks++; if (fq.cancel_cnt !== 2'd0) begin errors++; $display("FAIL reset_cancel: got %0d want 0", fq.cancel_cnt); end
      resetn = 1'b1;
      #1;
      checks++; if (fq.issue_allow !== 1'b1) begin errors++; $display("FAIL post_reset_allow: got %b want 1", fq.issue_allow); end
   endtask

   task automatic test_single_fetch();
      idle();
      fq.issue_valid = 1'b1;
      fq.issue_pc    = 32'h1C000000;
      tick();
      fq.issue_valid       = 1'b0;
      fq.inst_sram_data_ok = 1'b1;
      fq.inst_sram_rdata   = 32'h02800C0C;
      tick();
      fq.inst_sram_data_ok = 1'b0;
      checks++; if (fq.IF_to_ID_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", fq.IF_to_ID_valid); end
      checks++; if (fq.IF_to_ID_BUS !== {32'h1C000000, 32'h02800C0C, 1'b0, 15'h0, 32'h0})
         begin errors++; $display("FAIL single_bus: got %h want %h", fq.IF_to_ID_BUS, {32'h1C000000, 32'h02800C0C, 1'b0, 15'h0, 32'h0}); end
      fq.ID_allowin = 1'b1;
      tick();
      fq.ID_allowin = 1'b0;
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", fq.IF_to_ID_valid); end
   endtask

   task automatic test_back_pressure();
      logic [31:0] pcs[$];
      logic [31:0] pc;
      pc = 32'h1C000200;
      idle();
      for (int c = 0; c < 8; c++) begin
         fq.issue_valid = m_allow();
         fq.issue_pc    = pc;
         if (m_allow()) begin
            pcs.push_back(pc);
            pc = pc + 32'd4;
         end
         fq.inst_sram_data_ok = m_rsp_legal();
         fq.inst_sram_rdata   = (m_pend.size() != 0) ? (m_pend[0].pc ^ 32'h0000FFFF) : 32'h0;
         tick();
         checks++; if (fq.issue_allow !== m_allow()) begin errors++; $display("FAIL bp_allow cyc%0d: got %b want %b", c, fq.issue_allow, m_allow()); end
      end
      idle();
      checks++; if (fq.issue_allow !== 1'b0) begin errors++; $display("FAIL bp_full_allow: got %b want 0", fq.issue_allow); end
      fq.ID_allowin = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (fq.IF_to_ID_valid !== 1'b1 || fq.IF_to_ID_BUS[111:80] !== pcs[k] ||
             fq.IF_to_ID_BUS[79:48] !== (pcs[k] ^ 32'h0000FFFF))
            begin errors++; $display("FAIL bp_drain%0d: got v=%b pc=%h inst=%h want pc=%h inst=%h", k,
                  fq.IF_to_ID_valid, fq.IF_to_ID_BUS[111:80], fq.IF_to_ID_BUS[79:48], pcs[k], pcs[k] ^ 32'h0000FFFF); end
         tick();
      end
      fq.ID_allowin = 1'b0;
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", fq.IF_to_ID_valid); end
      checks++; if (fq.issue_allow !== 1'b1) begin errors++; $display("FAIL bp_allow_back: got %b want 1", fq.issue_allow); end
   endtask

   task automatic test_flush_in_flight();
      idle();
      fq.issue_valid = 1'b1;
      fq.issue_pc    = 32'h1C0000F0;
      tick();
      fq.issue_pc    = 32'h1C0000F4;
      tick();
      fq.issue_valid     = 1'b0;
      fq.br_taken_cancel = 1'b1;
      tick();
      fq.br_taken_cancel = 1'b0;
      checks++; if (fq.cancel_cnt !== 2'd2) begin errors++; $display("FAIL fl_cancel2: got %0d want 2", fq.cancel_cnt); end
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", fq.IF_to_ID_valid); end
      checks++; if (fq.issue_allow !== 1'b0) begin errors++; $display("FAIL fl_allow0: got %b want 0", fq.issue_allow); end
      fq.inst_sram_data_ok = 1'b1;
      fq.inst_sram_rdata   = 32'hDEAD0001;
      tick();
      fq.inst_sram_data_ok = 1'b0;
      checks++; if (fq.cancel_cnt !== 2'd1) begin errors++; $display("FAIL fl_cancel1: got %0d want 1", fq.cancel_cnt); end
      checks++; if (fq.issue_allow !== 1'b1) begin errors++; $display("FAIL fl_allow1: got %b want 1", fq.issue_allow); end
      fq.issue_valid = 1'b1;
      fq.issue_pc    = 32'h1C000100;
      tick();
      fq.issue_valid = 1'b0;
      checks++; if (fq.issue_allow !== 1'b0) begin errors++; $display("FAIL fl_allow_full: got %b want 0", fq.issue_allow); end
      fq.inst_sram_data_ok = 1'b1;
      fq.inst_sram_rdata   = 32'hDEAD0002;
      tick();
      checks++; if (fq.cancel_cnt !== 2'd0 || fq.IF_to_ID_valid !== 1'b0)
         begin errors++; $display("FAIL fl_drop2: got cancel=%0d valid=%b want 0 0", fq.cancel_cnt, fq.IF_to_ID_valid); end
      fq.inst_sram_rdata = 32'h4C000020;
      tick();
      fq.inst_sram_data_ok = 1'b0;
      checks++; if (fq.IF_to_ID_BUS !== {32'h1C000100, 32'h4C000020, 1'b0, 15'h0, 32'h0} || fq.IF_to_ID_valid !== 1'b1)
         begin errors++; $display("FAIL fl_deliver: got v=%b bus=%h want 1 %h", fq.IF_to_ID_valid, fq.IF_to_ID_BUS, {32'h1C000100, 32'h4C000020, 1'b0, 15'h0, 32'h0}); end
      fq.ID_allowin = 1'b1;
      tick();
      fq.ID_allowin = 1'b0;
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL fl_pop: got %b want 0", fq.IF_to_ID_valid); end
   endtask

   task automatic test_flush_concurrent();
      idle();
      fq.issue_valid = 1'b1;
      fq.issue_pc    = 32'h1C000300;
      tick();
      fq.issue_pc          = 32'h1C000304;
      fq.wb_ex             = 1'b1;
      fq.inst_sram_data_ok = 1'b1;
      fq.inst_sram_rdata   = 32'h11112222;
      fq.ID_allowin        = 1'b1;
      tick();
      fq.issue_valid = 1'b0;
      fq.wb_ex       = 1'b0;
      checks++; if (fq.cancel_cnt !== 2'd1) begin errors++; $display("FAIL fc_cancel: got %0d want 1", fq.cancel_cnt); end
      checks++; if (fq.IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL fc_valid: got %b want 0", fq.IF_to_ID_valid); end
      fq.inst_sram_rdata = 32'h33334444;
      tick();
      fq.inst_sram_data_ok = 1'b0;
      checks++; if (fq.cancel_cnt !== 2'd0 || fq.IF_to_ID_valid !== 1'b0 || fq.issue_allow !== 1'b1)
         begin errors++; $display("FAIL fc_drop: got cancel=%0d valid=%b allow=%b want 0 0 1", fq.cancel_cnt, fq.IF_to_ID_valid, fq.issue_allow); end
      idle();
   endtask

   task automatic test_exception_fetch();
      idle();
      fq.issue_valid    = 1'b1;
      fq.issue_ex       = 1'b1;
      fq.issue_pc       = 32'h1C000003;
      fq.issue_ex_code  = 15'h0004;
      fq.issue_ex_vaddr = 32'h1C000003;
      tick();
      idle();
      checks++; if (fq.issue_allow !== 1'b0) begin errors++; $display("FAIL ex_hold: got %b want 0", fq.issue_allow); end
      tick();
      checks++; if (fq.IF_to_ID_valid !== 1'b1 || fq.IF_to_ID_BUS !== {32'h1C000003, 32'h0, 1'b1, 15'h0004, 32'h1C000003})
         begin errors++; $display("FAIL ex_entry: got v=%b bus=%h want 1 %h", fq.IF_to_ID_valid, fq.IF_to_ID_BUS, {32'h1C000003, 32'h0, 1'b1, 15'h0004, 32'h1C000003}); end
      fq.ID_allowin = 1'b1;
      tick();
      tick();
      checks++; if (fq.issue_allow !== 1'b0 || fq.IF_to_ID_valid !== 1'b0)
         begin errors++; $display("FAIL ex_still_held: got allow=%b valid=%b want 0 0", fq.issue_allow, fq.IF_to_ID_valid); end
      fq.wb_ex = 1'b1;
      tick();
      fq.wb_ex = 1'b0;
      checks++; if (fq.issue_allow !== 1'b1 || fq.cancel_cnt !== 2'd0)
         begin errors++; $display("FAIL ex_release: got allow=%b cancel=%0d want 1 0", fq.issue_allow, fq.cancel_cnt); end
      idle();
   endtask

   task automatic test_async_reset();
      // full buffer, then reset between clock edges
      idle();
      fq.issue_valid = 1'b1; fq.issue_pc = 32'h1C000400; tick();
      fq.issue_pc = 32'h1C000404; fq.inst_sram_data_ok = 1'b1; fq.inst_sram_rdata = 32'hA0; tick();
      fq.issue_pc = 32'h1C000408; fq.inst_sram_rdata = 32'hA1; tick();
      fq.issue_valid = 1'b0; fq.inst_sram_rdata = 32'hA2; tick();
      idle();
      checks++; if (fq.IF_to_ID_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", fq.IF_to_ID_valid); end
      #2 resetn = 1'b0;
      model_clear();
      #1;
      checks++; if (fq.IF_to_ID_valid !== 1'b0 || fq.IF_to_ID_BUS !== 112'h0 || fq.issue_allow !== 1'b0)
         begin errors++; $display("FAIL ar_buf: got valid=%b bus=%h allow=%b want 0 0 0", fq.IF_to_ID_valid, fq.IF_to_ID_BUS, fq.issue_allow); end
      @(posedge clk); #1; resetn = 1'b1;
      // stale responses outstanding, then reset between clock edges
      fq.issue_valid = 1'b1; fq.issue_pc = 32'h1C000500; tick();
      fq.issue_pc = 32'h1C000504; tick();
      fq.issue_valid = 1'b0; fq.ertn_flush = 1'b1; tick();
      idle();
      checks++; if (fq.cancel_cnt !== 2'd2) begin errors++; $display("FAIL ar_pre_cancel: got %0d want 2", fq.cancel_cnt); end
      #2 resetn = 1'b0;
      model_clear();
      #1;
      checks++; if (fq.cancel_cnt !== 2'd0) begin errors++; $display("FAIL ar_cancel: got %0d want 0", fq.cancel_cnt); end
      @(posedge clk); #1; resetn = 1'b1;
   endtask

   task automatic test_random();
      bit fl;
      for (int c = 0; c < 800; c++) begin
         idle();
         fq.issue_valid = m_allow() && ($urandom_range(0, 3) != 0);
         fq.issue_pc    = 32'h1C000000 + ($urandom_range(0, 1023) << 2);
         if (fq.issue_valid && $urandom_range(0, 19) == 0) begin
            fq.issue_ex       = 1'b1;
            fq.issue_ex_code  = 15'($urandom_range(1, 32767));
            fq.issue_ex_vaddr = $urandom();
         end
         fq.inst_sram_data_ok = m_rsp_legal() && ($urandom_range(0, 2) != 0);
         fq.inst_sram_rdata   = $urandom();
         fq.ID_allowin        = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 29) == 0) || (m_hold && $urandom_range(0, 7) == 0);
         if (fl) begin
            case ($urandom_range(0, 2))
               0:       fq.wb_ex           = 1'b1;
               1:       fq.ertn_flush      = 1'b1;
               default: fq.br_taken_cancel = 1'b1;
            endcase
         end
         tick();
         checks++; if (fq.IF_to_ID_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc%0d: got %b want %b", c, fq.IF_to_ID_valid, exp_q.size() != 0); end
         checks++; if (fq.IF_to_ID_BUS !== m_bus()) begin errors++; $display("FAIL rnd_bus cyc%0d: got %h want %h", c, fq.IF_to_ID_BUS, m_bus()); end
         checks++; if (fq.issue_allow !== m_allow()) begin errors++; $display("FAIL rnd_allow cyc%0d: got %b want %b", c, fq.issue_allow, m_allow()); end
         checks++; if (32'(fq.cancel_cnt) !== 32'(m_cancel)) begin errors++; $display("FAIL rnd_cancel cyc%0d: got %0d want %0d", c, fq.cancel_cnt, m_cancel); end
      end
      idle();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_fetch();
      test_back_pressure();
      test_flush_in_flight();
      test_flush_concurrent();
      test_exception_fetch();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
